// File: rtl/flags_reg_if.sv
// +----------------------------------------------------------------------+
// | Module      : flags_reg_if                                           |
// | Description : Bus between the ALU/microcode engine and the FLAGS     |
// |               register stage (flag writes, instruction boundary      |
// |               pulses, interrupt/trap sequencing outputs).            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

interface flags_reg_if;
  logic [15:0] alu_flags;
  logic        update;
  logic [15:0] update_mask;
  logic        ss_write;
  logic        instr_start;
  logic        instr_done;
  logic        int_enter;
  logic        trap_ack;
  logic [15:0] flags;
  logic        irq_enable;
  logic        trap_req;

  // Microcode / ALU side
  modport master (
    output alu_flags, update, update_mask, ss_write,
           instr_start, instr_done, int_enter, trap_ack,
    input  flags, irq_enable, trap_req
  );

  // FLAGS register side
  modport slave (
    input  alu_flags, update, update_mask, ss_write,
           instr_start, instr_done, int_enter, trap_ack,
    output flags, irq_enable, trap_req
  );
endinterface

`default_nettype wire

// File: rtl/flags_reg.sv
// +----------------------------------------------------------------------+
// | Module      : flags_reg                                              |
// | Description : Architectural 8086 FLAGS register. Masked capture of   |
// |               ALU flags, fixed-bit forcing, one-instruction          |
// |               interrupt shadow (STI / SS write) and single-step      |
// |               trap request.                                          |
// | Options     : FLAGS_REG_TRAP_EN - build the TF latch and trap_req    |
// |               logic; otherwise trap_req is tied low.                 |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module flags_reg (
  input  logic        clk,
  input  logic        reset_n,
  flags_reg_if.slave  bus
);

  // Writable flag positions: CF PF AF ZF SF TF IF DF OF
  localparam logic [15:0] c_DEF_MASK  = 16'h0FD5;
  // Bits 15:12 and 1 read as one; 5 and 3 read as zero
  localparam logic [15:0] c_FIXED_ONE = 16'hF002;
  localparam int          c_TF        = 8;
  localparam int          c_IF        = 9;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_SHADOW = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_flags;
  logic [15:0] w_flags_nxt;
  logic [15:0] w_wr_mask;
  logic        w_sti;
  logic        w_arm;
  logic        r_irq;

  // Next FLAGS value: masked merge, int_enter override, fixed bits forced
  always_comb begin
    w_wr_mask   = bus.update ? (bus.update_mask & c_DEF_MASK) : 16'h0000;
    w_flags_nxt = (r_flags & ~w_wr_mask) | (bus.alu_flags & w_wr_mask);
    if (bus.int_enter) begin
      w_flags_nxt[c_IF] = 1'b0;
      w_flags_nxt[c_TF] = 1'b0;
    end
    w_flags_nxt = (w_flags_nxt & c_DEF_MASK) | c_FIXED_ONE;
  end

  // An STI is a masked write that raises IF, unless entry microcode clears it
  assign w_sti = bus.update & bus.update_mask[c_IF] & bus.alu_flags[c_IF] &
                 ~r_flags[c_IF] & ~bus.int_enter;
  assign w_arm = w_sti | bus.ss_write;

  // Shadow FSM next state; interrupt entry always wins
  always_comb begin
    w_state_nxt = r_state;
    if (bus.int_enter) begin
      w_state_nxt = S_IDLE;
    end else if (w_arm) begin
      w_state_nxt = bus.instr_done ? S_SHADOW : S_ARMED;
    end else begin
      case (r_state)
        S_ARMED:  if (bus.instr_done) w_state_nxt = S_SHADOW;
        S_SHADOW: if (bus.instr_done) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FLAGS, shadow state and irq_enable registers; irq_enable is built from
  // the next-state values so it tracks IF & IDLE with no added latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= c_FIXED_ONE;
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_flags <= w_flags_nxt;
      r_state <= w_state_nxt;
      r_irq   <= w_flags_nxt[c_IF] & (w_state_nxt == S_IDLE);
    end
  end

  assign bus.flags      = r_flags;
  assign bus.irq_enable = r_irq;

`ifdef FLAGS_REG_TRAP_EN
  logic r_tf_lat;
  logic r_trap;
  logic w_tf_eff;
  logic w_trap_set;

  // The latch samples TF at instr_start; a same-cycle instr_done sees it
  assign w_tf_eff   = bus.instr_start ? r_flags[c_TF] : r_tf_lat;
  // No trap after the instruction that opened an interrupt shadow
  assign w_trap_set = bus.instr_done & w_tf_eff & (r_state != S_ARMED);

  // TF latch and trap request; a set beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tf_lat <= 1'b0;
      r_trap   <= 1'b0;
    end else begin
      r_tf_lat <= bus.int_enter ? 1'b0 : w_tf_eff;
      if (w_trap_set) begin
        r_trap <= 1'b1;
      end else if (bus.trap_ack || bus.int_enter) begin
        r_trap <= 1'b0;
      end
    end
  end

  assign bus.trap_req = r_trap;
`else
  logic w_unused_trap_inputs;
  assign w_unused_trap_inputs = bus.trap_ack ^ bus.instr_start;
  assign bus.trap_req = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/flags_reg.md
# flags_reg

Architectural FLAGS register stage directly downstream of the ALU. It captures ALU flag results under a per-bit write mask and forces the 8086 fixed bits. It also implements the one-instruction interrupt shadow after STI or a write to SS, and the single-step trap request. Its registered `flags` output feeds the ALU `flags_in` port and the interrupt/trap sequencing in the microcode engine.

## Interface

Parameters: none.

Ports:
- `clk`  input  1  core clock; all state updates on its rising edge.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `alu_flags`  input  16  flag vector from the ALU `flags_out`.
- `update`  input  1  write strobe; one cycle per write.
- `update_mask`  input  16  per-bit write enable while `update`=1. Only defined bits are honoured: CF(0) PF(2) AF(4) ZF(6) SF(7) TF(8) IF(9) DF(10) OF(11).
- `ss_write`  input  1  pulse: SS was written (MOV/POP SS); arms the interrupt shadow.
- `instr_start`  input  1  pulse: first microcode cycle of an instruction.
- `instr_done`  input  1  pulse: last cycle of an instruction.
- `int_enter`  input  1  pulse: interrupt/trap entry microcode is clearing IF and TF.
- `trap_ack`  input  1  pulse: the microcode has accepted `trap_req`.
- `flags`  output  16  registered architectural FLAGS.
- `irq_enable`  output  1  maskable interrupts may be taken at the next boundary.
- `trap_req`  output  1  single-step trap pending.

## Operation

- **Fixed bits.** `flags` bits 15:12 and bit 1 always read 1; bits 5 and 3 always read 0. Masked writes to these bits are ignored.
- **Reset.** `flags`=16'hF002, `irq_enable`=0, `trap_req`=0, shadow FSM=IDLE, TF latch=0.
- **Masked write.** On `update`, each defined bit i with `update_mask[i]`=1 takes `alu_flags[i]`. Unmasked bits hold.
- **int_enter.** Forces IF=0 and TF=0 and overrides any simultaneous `update` to those two bits. Other masked bits from the same-cycle `update` still apply.
- **STI detect.** An IF rising edge is an `update` with IF masked that changes IF from 0 to 1, and no `int_enter` in the same cycle.
- **Shadow FSM**, three states:
  - IDLE: on STI detect or `ss_write`, go to ARMED; if `instr_done` is also high that cycle, go straight to SHADOW.
  - ARMED: on `instr_done`, go to SHADOW. The instruction containing the STI completes here.
  - SHADOW: on `instr_done`, go to IDLE. The following instruction completes here.
  - A new STI detect or `ss_write` in ARMED or SHADOW restarts at ARMED, or at SHADOW if `instr_done` is high the same cycle.
  - `int_enter` forces IDLE.
- `irq_enable` = registered IF AND (state == IDLE), with no extra delay.
- **Single-step.** On `instr_start`, the TF latch samples the current registered TF. On `instr_done` with the TF latch set and state not ARMED, `trap_req` is set.
  - `trap_req` holds until `trap_ack` or `int_enter`.
  - If a set and a clear occur in the same cycle, the set wins.
  - `int_enter` also clears the TF latch.

## Timing

- Write latency is 1 cycle: an `update` at cycle N is visible on `flags` at N+1. There is no combinational bypass; the microcode never reads flags in the same cycle it writes them.
- `irq_enable` falls in the cycle after the STI/`ss_write` write edge. It rises in the cycle after the second qualifying `instr_done`.
- `trap_req` rises 1 cycle after the qualifying `instr_done` and falls 1 cycle after `trap_ack`.
- `instr_start` and `instr_done` in the same cycle (single-cycle instruction): the TF latch samples first, then `instr_done` evaluates using the newly sampled value.
- Asserting `reset_n` low mid-instruction returns every output to its reset value immediately, independent of `clk`.
- All outputs are glitch-free register outputs.

## Configuration

- `FLAGS_REG_TRAP_EN` defined: the TF latch and `trap_req` logic are present as described above.
- Not defined:
  - the TF latch is not built and `trap_req` is tied to 0;
  - TF is still stored in `flags`, writable, and cleared by `int_enter`;
  - `trap_ack` is ignored.

## Test plan

- **Reset and fixed bits.** Release `reset_n`: `flags`=F002, `irq_enable`=0. Then `update` with mask FFFF and `alu_flags`=0000: `flags`=F002. Then mask FFFF with `alu_flags`=FFFF: `flags`=FFD7.
- **Partial write.** From `flags`=F002, `update` with mask 0x0001 and `alu_flags`=FFFF: `flags`=F003 one cycle later, all other bits unchanged.
- **STI shadow.** IF=0. Write IF=1 (mask 0x0200) then pulse `instr_done`: `irq_enable` stays 0. Second `instr_done`: `irq_enable`=1 on the next cycle.
- **SS shadow.** IF=1, `irq_enable`=1. Pulse `ss_write`: `irq_enable`=0 next cycle. After two `instr_done` pulses: `irq_enable`=1.
- **Single-step** (`FLAGS_REG_TRAP_EN`). Set TF, then pulse `instr_start` and `instr_done`: `trap_req`=1. Pulse `trap_ack`: `trap_req`=0. Pulse `int_enter`: `flags`=F002 when only TF and IF were set.
- **Collision.** `update` setting IF and TF in the same cycle as `int_enter`, with CF masked high: IF=0, TF=0, CF=1, FSM=IDLE.
